// File: rtl/uart_fifo_mmio.sv
// uart_fifo_mmio: memory-mapped UART with independent RX/TX FIFOs, sticky error flags and a level irq.
// Define UART_PARITY_EN to add an even-parity bit to every frame (RX mismatches reported in STATUS[5]).

module uart_fifo_mmio_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic             full, empty, do_push, do_pop;

    // a full FIFO still takes a push when the same cycle pops; an empty one ignores the pop
    always_comb begin
        empty   = (wptr_q == rptr_q);
        full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wptr_d  = wptr_q + {{AW{1'b0}}, do_push};
        rptr_d  = rptr_q + {{AW{1'b0}}, do_pop};
        dout    = mem[rptr_q[AW-1:0]];
        count   = wptr_q - rptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q[AW-1:0]] <= din;
    end
endmodule

module uart_fifo_mmio #(
    parameter int CLK_HZ    = 27000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int RX_DEPTH  = 16,
    parameter int TX_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  addr,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        irq
);
    localparam int CYCLE = CLK_HZ / BAUD;
    localparam int CNT_W = $clog2(CYCLE);
    localparam int BIT_W = $clog2(DATA_BITS);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLE - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CYCLE / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
`ifdef UART_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_e;

    state_e                 tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [CNT_W-1:0]       tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [BIT_W-1:0]       tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0]   tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic                   tx_par_q, tx_par_d;
    logic [1:0]             rx_sync_q, rx_sync_d;
    logic                   rx_brk_q, rx_brk_d;
    logic [1:0]             ctrl_q, ctrl_d;
    logic                   ovr_q, ovr_d, fe_q, fe_d, pe_q, pe_d, irq_q, irq_d;

    logic                   tx_push, tx_pop, rx_push, rx_pop, wr_status;
    logic [DATA_BITS-1:0]   tx_dout, rx_dout;
    logic [TX_AW:0]         tx_count;
    logic [RX_AW:0]         rx_count;
    logic                   tx_empty, tx_full, rx_empty, rx_full, tx_idle, rx_s;
    logic                   tx_last, rx_last, fe_set, ovr_set, pe_set;
    logic [31:0]            status;
    logic                   unused_wr_bits;

    uart_fifo_mmio_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push), .din(wr_data[DATA_BITS-1:0]),
        .pop(tx_pop), .dout(tx_dout), .count(tx_count)
    );

    uart_fifo_mmio_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_push), .din(rx_sh_d),
        .pop(rx_pop), .dout(rx_dout), .count(rx_count)
    );

    assign unused_wr_bits = ^wr_data;
    assign tx_empty  = (tx_count == '0);
    assign tx_full   = (tx_count == (TX_AW+1)'(TX_DEPTH));
    assign rx_empty  = (rx_count == '0);
    assign rx_full   = (rx_count == (RX_AW+1)'(RX_DEPTH));
    assign rx_s      = rx_sync_q[1];
    assign rx_sync_d = {rx_sync_q[0], uart_rx};

    always_comb begin
        wr_status = wr_en && (addr == 2'd1);
        tx_push   = wr_en && (addr == 2'd2);
        rx_pop    = rd_en && (addr == 2'd0);
        ctrl_d    = (wr_en && addr == 2'd3) ? wr_data[1:0] : ctrl_q;
    end

    // TX next state; a new frame is popped and started straight from STOP to avoid idle gaps
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        tx_pop     = 1'b0;
        tx_last    = (tx_cnt_q == CNT_LAST);
        if (tx_state_q != S_IDLE) tx_cnt_d = tx_last ? '0 : tx_cnt_q + CNT_W'(1);
        case (tx_state_q)
            S_IDLE: if (!tx_empty) begin
                tx_pop     = 1'b1;
                tx_state_d = S_START;
                tx_cnt_d   = '0;
                tx_sh_d    = tx_dout;
                tx_par_d   = ^tx_dout;
            end
            S_START: if (tx_last) begin
                tx_state_d = S_DATA;
                tx_bit_d   = '0;
            end
            S_DATA: if (tx_last) begin
                tx_sh_d  = tx_sh_q >> 1;
                tx_bit_d = tx_bit_q + BIT_W'(1);
                if (tx_bit_q == BIT_LAST) begin
                    if (PARITY_EN) tx_state_d = S_PAR;
                    else           tx_state_d = S_STOP;
                end
            end
            S_PAR: if (tx_last) tx_state_d = S_STOP;
            S_STOP: if (tx_last) begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_d = S_START;
                    tx_sh_d    = tx_dout;
                    tx_par_d   = ^tx_dout;
                end else begin
                    tx_state_d = S_IDLE;
                end
            end
            default: tx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tx_idle = tx_empty && (tx_state_q == S_IDLE);
        case (tx_state_q)
            S_START: uart_tx = 1'b0;
            S_DATA:  uart_tx = tx_sh_q[0];
            S_PAR:   uart_tx = tx_par_q;
            default: uart_tx = 1'b1;
        endcase
    end

    // RX next state; after a framing error the line must return high before a new start is accepted
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_brk_d   = rx_brk_q;
        rx_push    = 1'b0;
        fe_set     = 1'b0;
        ovr_set    = 1'b0;
        pe_set     = 1'b0;
        rx_last    = (rx_cnt_q == CNT_LAST);
        if (rx_state_q != S_IDLE) rx_cnt_d = rx_last ? '0 : rx_cnt_q + CNT_W'(1);
        case (rx_state_q)
            S_IDLE: begin
                rx_brk_d = rx_brk_q && !rx_s;
                if (!rx_brk_q && !rx_s) begin
                    rx_state_d = S_START;
                    rx_cnt_d   = '0;
                end
            end
            S_START: if (rx_cnt_q == CNT_HALF) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: if (rx_last) begin
                rx_sh_d  = {rx_s, rx_sh_q[DATA_BITS-1:1]};
                rx_bit_d = rx_bit_q + BIT_W'(1);
                if (rx_bit_q == BIT_LAST) begin
                    if (PARITY_EN) rx_state_d = S_PAR;
                    else           rx_state_d = S_STOP;
                end
            end
            S_PAR: if (rx_last) begin
                pe_set     = PARITY_EN && (rx_s != ^rx_sh_q);
                rx_state_d = S_STOP;
            end
            S_STOP: if (rx_last) begin
                rx_state_d = S_IDLE;
                if (!rx_s) begin
                    fe_set   = 1'b1;
                    rx_brk_d = 1'b1;
                end else if (rx_full) begin
                    ovr_set = 1'b1;
                end else begin
                    rx_push = 1'b1;
                end
            end
            default: rx_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ovr_d  = ovr_set || (ovr_q && !(wr_status && wr_data[2]));
        fe_d   = fe_set  || (fe_q  && !(wr_status && wr_data[3]));
        pe_d   = pe_set  || (pe_q  && !(wr_status && wr_data[5]));
        irq_d  = (ctrl_q[0] && !rx_empty) || (ctrl_q[1] && tx_idle) || ovr_q || fe_q
                 || (PARITY_EN && pe_q);
        status = {16'h0, 8'(rx_count), 2'b00, pe_q, tx_idle, fe_q, ovr_q, !tx_full, !rx_empty};
        case (addr)
            2'd0:    rd_data = rx_empty ? 32'h0 : 32'(rx_dout);
            2'd1:    rd_data = status;
            2'd3:    rd_data = {30'h0, ctrl_q};
            default: rd_data = 32'h0;
        endcase
    end

    assign irq = irq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sync_q  <= 2'b11;
            rx_brk_q   <= 1'b0;
            ctrl_q     <= 2'b00;
            ovr_q      <= 1'b0;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sync_q  <= rx_sync_d;
            rx_brk_q   <= rx_brk_d;
            ctrl_q     <= ctrl_d;
            ovr_q      <= ovr_d;
            fe_q       <= fe_d;
            pe_q       <= pe_d;
            irq_q      <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        tx_sh_q  <= tx_sh_d;
        tx_par_q <= tx_par_d;
        rx_sh_q  <= rx_sh_d;
    end
endmodule
